// File: rtl/axi_rd_split_pkg.sv
// Shared encodings, FSM state and tag type for the AXI4 read burst splitter.
// The optional sticky-error feature is selected by AXI_RD_SPLIT_STICKY_ERR_EN.
package axi_rd_split_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        NEXT
    } state_t;

    typedef struct packed {
        logic last;
    } tag_t;

    // Numeric order already ranks DECERR > SLVERR > OKAY.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_rd_split_if.sv
// AXI4 read-channel bundle (AR + R) with initiator (master) and target (slave) views.
interface axi_rd_split_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_split_tag_fifo.sv
// Small FIFO of per-sub-burst tags; head is readable combinationally for the R path.
module axi_rd_split_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign full     = (count_reg == (PW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/axi_rd_split.sv
// Splits AXI4 read bursts into sub-bursts of at most MAX_BURST_LEN beats and re-merges rlast.
// Define AXI_RD_SPLIT_STICKY_ERR_EN to carry the worst rresp forward through each original burst.
module axi_rd_split
    import axi_rd_split_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16,
    parameter int OUTSTANDING   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    axi_rd_split_if.slave  s_axi,
    axi_rd_split_if.master m_axi
);
    localparam logic [8:0]            MAX9     = 9'(MAX_BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MAX_BURST_LEN);

    state_t                state_reg, state_next;
    logic                  init_done_reg;
    logic [8:0]            remaining_reg;
    logic [8:0]            remaining_after;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [2:0]            size_reg;
    logic [1:0]            burst_reg;
    logic                  lock_reg;
    logic [3:0]            cache_reg;
    logic [2:0]            prot_reg;
    logic [3:0]            qos_reg;
    logic [3:0]            region_reg;
    logic                  ar_ready;
    logic                  ar_valid;
    logic                  s_ar_fire;
    logic                  m_ar_fire;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_pop;
    tag_t                  push_tag;
    tag_t                  head_tag;

    function automatic logic [7:0] clip_len(input logic [8:0] beats);
        if (beats > MAX9) begin
            return 8'(MAX9 - 9'd1);
        end
        return 8'(beats - 9'd1);
    endfunction

    assign s_ar_fire       = s_axi.arvalid && ar_ready;
    assign m_ar_fire       = ar_valid && m_axi.arready;
    assign remaining_after = remaining_reg - ({1'b0, len_reg} + 9'd1);
    assign push_tag.last   = (remaining_after == 9'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_done_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (s_ar_fire) state_next = ISSUE;
            ISSUE:   if (m_ar_fire) state_next = (remaining_after == 9'd0) ? IDLE : NEXT;
            NEXT:    state_next = ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // arvalid depends only on registered state, never on m_axi.arready.
    always_comb begin
        ar_ready = 1'b0;
        ar_valid = 1'b0;
        case (state_reg)
            IDLE:    ar_ready = init_done_reg;
            ISSUE:   ar_valid = !tag_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_reg <= '0;
            id_reg        <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            lock_reg      <= 1'b0;
            cache_reg     <= '0;
            prot_reg      <= '0;
            qos_reg       <= '0;
            region_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: if (s_ar_fire) begin
                    remaining_reg <= {1'b0, s_axi.arlen} + 9'd1;
                    id_reg        <= s_axi.arid;
                    addr_reg      <= s_axi.araddr;
                    len_reg       <= (s_axi.arburst == BURST_WRAP) ? s_axi.arlen
                                                                   : clip_len({1'b0, s_axi.arlen} + 9'd1);
                    size_reg      <= s_axi.arsize;
                    burst_reg     <= s_axi.arburst;
                    lock_reg      <= s_axi.arlock;
                    cache_reg     <= s_axi.arcache;
                    prot_reg      <= s_axi.arprot;
                    qos_reg       <= s_axi.arqos;
                    region_reg    <= s_axi.arregion;
                end
                ISSUE: if (m_ar_fire) begin
                    remaining_reg <= remaining_after;
                end
                NEXT: begin
                    if (burst_reg == BURST_INCR) begin
                        addr_reg <= addr_reg + (MAX_ADDR << size_reg);
                    end
                    len_reg <= clip_len(remaining_reg);
                end
                default: ;
            endcase
        end
    end

    assign s_axi.arready  = ar_ready;
    assign m_axi.arvalid  = ar_valid;
    assign m_axi.arid     = id_reg;
    assign m_axi.araddr   = addr_reg;
    assign m_axi.arlen    = len_reg;
    assign m_axi.arsize   = size_reg;
    assign m_axi.arburst  = burst_reg;
    assign m_axi.arlock   = lock_reg;
    assign m_axi.arcache  = cache_reg;
    assign m_axi.arprot   = prot_reg;
    assign m_axi.arqos    = qos_reg;
    assign m_axi.arregion = region_reg;

    assign tag_pop = m_axi.rvalid && m_axi.rready && m_axi.rlast;

    axi_rd_split_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (m_ar_fire),
        .push_data (push_tag.last),
        .pop       (tag_pop),
        .pop_data  (head_tag.last),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign m_axi.rready = s_axi.rready && !tag_empty;
    assign s_axi.rvalid = m_axi.rvalid && !tag_empty;
    assign s_axi.rid    = m_axi.rid;
    assign s_axi.rdata  = m_axi.rdata;
    assign s_axi.rlast  = m_axi.rlast && head_tag.last;

`ifdef AXI_RD_SPLIT_STICKY_ERR_EN
    logic [1:0] err_reg;
    logic [1:0] resp_out;

    assign resp_out    = resp_worst(m_axi.rresp, err_reg);
    assign s_axi.rresp = resp_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= RESP_OKAY;
        end else if (s_axi.rvalid && s_axi.rready) begin
            err_reg <= s_axi.rlast ? RESP_OKAY : resp_out;
        end
    end
`else
    assign s_axi.rresp = m_axi.rresp;
`endif

endmodule
